// File: rtl/knn_vote_unit.sv
// K-nearest-neighbour vote stage: keeps the K smallest distances in sorted slots, then majority-votes their labels.
// Optional build macro KNN_TIE_NEAREST_EN: break vote ties by the nearest tied slot instead of the lowest class index.
//
// state  | meaning
// IDLE   | waiting for start after reset
// REQ    | data_request pulse for the next training sample
// WAIT   | waiting for done, then insert the sample
// VOTE   | one kept slot per cycle adds to its class counter
// DECIDE | argmax of the class counters into result_type
// DONE   | result held; result_valid on the first cycle only
module knn_vote_unit #(
  parameter int W            = 32,
  parameter int TYPE_W       = 2,
  parameter int K            = 3,
  parameter int MAX_ELEMENTS = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      distance,
  input  logic [TYPE_W-1:0] data_type,
  input  logic              done,
  output logic              data_request,
  output logic              busy,
  output logic [TYPE_W-1:0] result_type,
  output logic              result_valid,
  output logic [W-1:0]      nearest_dist
);

  localparam int NCLS  = 1 << TYPE_W;
  localparam int CNT_W = $clog2(MAX_ELEMENTS + 1);
  localparam int VC_W  = $clog2(K + 1);
  localparam int VI_W  = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(MAX_ELEMENTS);
  localparam logic [VI_W-1:0]  LAST_SLOT   = VI_W'(K - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VOTE, S_DECIDE, S_DONE} state_t;

  state_t            state;
  logic [K-1:0]      slot_valid;
  logic [W-1:0]      slot_dist [K];
  logic [TYPE_W-1:0] slot_type [K];
  logic [CNT_W-1:0]  sample_cnt;
  logic [VI_W-1:0]   vote_idx;
  logic [VC_W-1:0]   vote_cnt [NCLS];

  logic [K-1:0]      gt;
  logic [K:0]        gt_ext;
  logic [K-1:0]      nx_valid;
  logic [W-1:0]      nx_dist [K];
  logic [TYPE_W-1:0] nx_type [K];

  logic [VC_W-1:0]   best_cnt;
  logic [TYPE_W-1:0] best_cls;
  logic [TYPE_W-1:0] winner;

  assign nearest_dist = slot_dist[0];

  // Valid slots are packed at the front and sorted, so gt is monotone: the first set bit is the insert point.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      gt[i] = !slot_valid[i] || (slot_dist[i] > distance);
    end
    gt_ext = {gt, 1'b0};
    for (int i = 0; i < K; i++) begin
      nx_valid[i] = slot_valid[i];
      nx_dist[i]  = slot_dist[i];
      nx_type[i]  = slot_type[i];
      if (gt[i] && !gt_ext[i]) begin
        nx_valid[i] = 1'b1;
        nx_dist[i]  = distance;
        nx_type[i]  = data_type;
      end
    end
    for (int i = 1; i < K; i++) begin
      if (gt[i] && gt_ext[i]) begin
        nx_valid[i] = slot_valid[i-1];
        nx_dist[i]  = slot_dist[i-1];
        nx_type[i]  = slot_type[i-1];
      end
    end
  end

  always_comb begin
    best_cnt = '0;
    best_cls = '0;
    for (int c = 0; c < NCLS; c++) begin
      if (vote_cnt[c] > best_cnt) begin
        best_cnt = vote_cnt[c];
        best_cls = TYPE_W'(c);
      end
    end
    winner = best_cls;
`ifdef KNN_TIE_NEAREST_EN
    // Scan far-to-near so the nearest slot belonging to a maximal class wins last.
    for (int i = K - 1; i >= 0; i--) begin
      if (slot_valid[i] && (best_cnt != '0) && (vote_cnt[slot_type[i]] == best_cnt)) begin
        winner = slot_type[i];
      end
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      data_request <= 1'b0;
      busy         <= 1'b0;
      result_type  <= '0;
      result_valid <= 1'b0;
      slot_valid   <= '0;
      sample_cnt   <= '0;
      vote_idx     <= '0;
      for (int i = 0; i < K; i++) begin
        slot_dist[i] <= '1;
        slot_type[i] <= '0;
      end
      for (int c = 0; c < NCLS; c++) vote_cnt[c] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          result_valid <= 1'b0;
          if (start) begin
            slot_valid   <= '0;
            for (int i = 0; i < K; i++) slot_dist[i] <= '1;
            sample_cnt   <= '0;
            data_request <= 1'b1;
            busy         <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          data_request <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            slot_valid <= nx_valid;
            for (int i = 0; i < K; i++) begin
              slot_dist[i] <= nx_dist[i];
              slot_type[i] <= nx_type[i];
            end
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (sample_cnt + CNT_W'(1) == LAST_SAMPLE) begin
              vote_idx <= '0;
              for (int c = 0; c < NCLS; c++) vote_cnt[c] <= '0;
              state <= S_VOTE;
            end else begin
              data_request <= 1'b1;
              state        <= S_REQ;
            end
          end
        end
        S_VOTE: begin
          if (slot_valid[vote_idx]) begin
            vote_cnt[slot_type[vote_idx]] <= vote_cnt[slot_type[vote_idx]] + VC_W'(1);
          end
          if (vote_idx == LAST_SLOT) begin
            state <= S_DECIDE;
          end else begin
            vote_idx <= vote_idx + VI_W'(1);
          end
        end
        S_DECIDE: begin
          result_type  <= winner;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote_unit.sv
// Directed bench for knn_vote_unit (K=3, MAX_ELEMENTS=5); responder answers 3 cycles after each data_request.
module tb_knn_vote_unit;
  localparam int W  = 32;
  localparam int TW = 2;
  localparam int K  = 3;
  localparam int ME = 5;
  localparam int NV = 6;

  logic          clk = 1'b0;
  logic          rst, start, done;
  logic [W-1:0]  distance;
  logic [TW-1:0] data_type;
  logic          data_request, busy, result_valid;
  logic [TW-1:0] result_type;
  logic [W-1:0]  nearest_dist;

  int cyc = 0, dr_cnt = 0, rv_cnt = 0;
  int n_vec = 0, n_err = 0;

  typedef struct {
    logic [W-1:0] d [5];
    int           t [5];
    int           exp_type;
    logic [W-1:0] exp_near;
  } vec_t;
  vec_t vecs [NV];

  knn_vote_unit #(.W(W), .TYPE_W(TW), .K(K), .MAX_ELEMENTS(ME)) dut (
    .clk(clk), .rst(rst), .start(start), .distance(distance), .data_type(data_type),
    .done(done), .data_request(data_request), .busy(busy), .result_type(result_type),
    .result_valid(result_valid), .nearest_dist(nearest_dist)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (data_request) dr_cnt = dr_cnt + 1;
    if (result_valid) rv_cnt = rv_cnt + 1;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_to_req", W'(data_request), 1);
  endtask

  // Entered on a negedge where data_request should be high; ends on the result_valid negedge (or after n samples).
  task automatic serve(input int v, input int n, input bit spur);
    int dr0, rv0, t, w;
    logic [W-1:0] near;
    dr0 = dr_cnt;
    rv0 = rv_cnt;
    t = 0;
    near = '1;
    for (int j = 0; j < n; j++) begin
      w = 0;
      while (!data_request && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("req_wait", W'(data_request), 1);
      if (!data_request) return;
      if (spur && j == 0) begin
        done = 1'b1; distance = '0; data_type = 2'd3;
      end
      @(negedge clk);
      done = 1'b0;
      if (spur && j == 0) begin
        start = 1'b1;
        chk("spur_done_req", nearest_dist, '1);
      end
      @(negedge clk);
      start = 1'b0;
      if (spur && j == 0) chk("start_while_busy", W'(data_request), 0);
      @(negedge clk);
      distance  = vecs[v].d[j];
      data_type = TW'(vecs[v].t[j]);
      done      = 1'b1;
      t         = cyc;
      if (vecs[v].d[j] < near) near = vecs[v].d[j];
      @(negedge clk);
      done = 1'b0;
      chk("nearest_run", nearest_dist, near);
      if (j < ME - 1) chk("req_after_done", W'(data_request), 1);
    end
    if (n < ME) return;
    if (spur) begin
      done = 1'b1; distance = W'(1); data_type = 2'd3;
      @(negedge clk);
      done = 1'b0;
    end
    w = 0;
    while (!result_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rv_wait", W'(result_valid), 1);
    chk("latency", W'(cyc - t), K + 2);
    chk("result_type", W'(result_type), W'(vecs[v].exp_type));
    chk("nearest_final", nearest_dist, vecs[v].exp_near);
    chk("req_count", W'(dr_cnt - dr0), ME);
    chk("rv_early", W'(rv_cnt - rv0), 0);
  endtask

  initial begin
    int rv_b;
    vecs[0].d = '{40, 10, 30, 20, 50};  vecs[0].t = '{1, 2, 1, 2, 3};
    vecs[0].exp_type = 2;  vecs[0].exp_near = 10;
    vecs[1].d = '{5, 7, 9, 100, 200};   vecs[1].t = '{3, 0, 1, 2, 2};
`ifdef KNN_TIE_NEAREST_EN
    vecs[1].exp_type = 3;
`else
    vecs[1].exp_type = 0;
`endif
    vecs[1].exp_near = 5;
    vecs[2].d = '{10, 10, 10, 10, 10};  vecs[2].t = '{1, 2, 3, 0, 0};
    vecs[2].exp_type = 1;  vecs[2].exp_near = 10;
    vecs[3].d = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3].t = '{2, 1, 1, 1, 1};
    vecs[3].exp_type = 1;  vecs[3].exp_near = 32'hFFFF_FFFF;
    vecs[4].d = '{3, 8, 1, 9, 2};       vecs[4].t = '{0, 1, 1, 0, 0};
    vecs[4].exp_type = 0;  vecs[4].exp_near = 1;
    vecs[5].d = '{50, 40, 30, 20, 10};  vecs[5].t = '{3, 3, 1, 1, 2};
    vecs[5].exp_type = 1;  vecs[5].exp_near = 10;

    rst = 1'b1; start = 1'b0; done = 1'b0; distance = '0; data_type = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", W'(data_request), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_type", W'(result_type), 0);
    chk("rst_rv", W'(result_valid), 0);
    chk("rst_near", nearest_dist, '1);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      rv_b = rv_cnt;
      do_start();
      serve(v, ME, 1'b0);
      @(negedge clk);
      chk("rv_one_cycle", W'(result_valid), 0);
      chk("rv_once", W'(rv_cnt - rv_b), 1);
      chk("idle_busy", W'(busy), 0);
    end

    // reset after the third done abandons the query
    do_start();
    serve(0, 3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", W'(data_request), 0);
    chk("mid_rst_busy", W'(busy), 0);
    chk("mid_rst_type", W'(result_type), 0);
    chk("mid_rst_rv", W'(result_valid), 0);
    chk("mid_rst_near", nearest_dist, '1);
    rv_b = rv_cnt;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_rv", W'(rv_cnt - rv_b), 0);
    do_start();
    serve(0, ME, 1'b0);
    @(negedge clk);

    // spurious done in REQ and VOTE, start while busy, then back-to-back start in the result_valid cycle
    do_start();
    serve(0, ME, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_req", W'(data_request), 1);
    chk("b2b_rv_low", W'(result_valid), 0);
    serve(2, ME, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/knn_vote_unit.md
# knn_vote_unit

Downstream stage of `distance_calculator` in the KNN system. It requests one training sample at a time and accepts each `distance`/`data_type` pair on the calculator's `done` pulse. It keeps a sorted list of the K smallest distances. After MAX_ELEMENTS samples it runs a majority vote over the kept labels and outputs the classified type.

## Interface

- `W`, 32: distance width; must match `distance_calculator`.
- `TYPE_W`, 2: class label width; 2^TYPE_W classes.
- `K`, 3: neighbours kept; 1 ≤ K ≤ 15.
- `MAX_ELEMENTS`, 30: training samples per query; ≥ 1.

Ports (clock and reset first):

- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a new query; honoured only in IDLE or DONE.
- `distance`  in  W: unsigned distance from `distance_calculator`.
- `data_type`  in  TYPE_W: label of that training sample.
- `done`  in  1: one-cycle valid strobe for `distance`/`data_type`.
- `data_request`  out  1: one-cycle pulse asking upstream for the next sample.
- `busy`  out  1: high in every state except IDLE and DONE.
- `result_type`  out  TYPE_W: classified label; held until the next `start`.
- `result_valid`  out  1: one-cycle pulse when `result_type` is updated.
- `nearest_dist`  out  W: distance in slot 0 (the smallest kept distance).

## Operation

- **Storage:** K slots, each holding {valid, dist[W-1:0], type[TYPE_W-1:0]}. Slot 0 is the nearest. A sample counter runs 0..MAX_ELEMENTS. There are 2^TYPE_W vote counters, each ⌈log2(K+1)⌉ bits wide.
- **States:**
  - IDLE: on `start`, clear all slots to valid=0, clear the counter, go to REQ.
  - REQ: `data_request`=1 for this one cycle; go to WAIT.
  - WAIT: stay until `done`=1. Then insert the sample and increment the counter. If the counter now equals MAX_ELEMENTS, go to VOTE; otherwise go to REQ.
  - VOTE: take K cycles, one slot per cycle. Each valid slot increments its type's counter. Counters are zeroed on VOTE entry.
  - DECIDE: one cycle. Register the argmax class into `result_type`; go to DONE.
  - DONE: `result_valid`=1 in the first DONE cycle only. On `start`, return to the IDLE clearing action and go to REQ.
- **Insertion:** one cycle, parallel compare and shift.
  - The new sample's position is the first slot that is invalid or has dist strictly greater than the new distance.
  - That slot and all later slots shift down one place; the last slot is dropped.
  - If no position exists, the sample is discarded. The counter still increments.
  - Equal distances are stable: the earlier-arriving sample stays nearer.
  - Validity comes only from the valid bit. A distance of all-ones is a legal value.
- **Ignored inputs:**
  - `done` outside WAIT is ignored.
  - `start` in REQ, WAIT, VOTE or DECIDE is ignored.
- **Small MAX_ELEMENTS:** if MAX_ELEMENTS < K, only valid slots vote.
- **Ties:** default tie-break is the lowest class index (see Configuration).

## Timing

- Reset values: `data_request`=0, `busy`=0, `result_type`=0, `result_valid`=0, `nearest_dist`=all-ones, all slots invalid, state IDLE.
- `rst` has priority over every other input in the same cycle. Reset mid-query abandons the query and issues no `result_valid`.
- `start` sampled at cycle t gives `data_request`=1 in cycle t+1.
- `done` at cycle t:
  - Slot update and `nearest_dist` are visible in cycle t+1.
  - If samples remain, `data_request` is high in cycle t+1.
- Last `done` at cycle t: VOTE occupies t+1..t+K, DECIDE is t+K+1, and `result_valid`=1 at t+K+2.
- `start` in the same cycle as the `result_valid` pulse is honoured.

## Configuration

- `KNN_TIE_NEAREST_EN`:
  - Defined: among classes tied for the maximum vote, pick the class of the lowest-index (nearest) valid slot in that tied set.
  - Undefined: pick the lowest numeric class index among the tied classes.
  - Both builds give identical results when there is no tie. If no slot is valid (impossible when MAX_ELEMENTS ≥ 1), `result_type`=0.

## Test plan

All scenarios use K=3, MAX_ELEMENTS=5, TYPE_W=2, W=32. The responder returns `done` 3 cycles after each `data_request`.

1. Basic classification. Samples (dist,type): (40,1), (10,2), (30,1), (20,2), (50,3).
   - Kept: 10/2, 20/2, 30/1.
   - Required: `result_type`=2, `nearest_dist`=10, `result_valid` exactly once, 5 `data_request` pulses, and latency K+2=5 cycles after the last `done`.
2. Three-way tie. Samples: (5,3), (7,0), (9,1), (100,2), (200,2).
   - Without the macro: `result_type`=0.
   - With `KNN_TIE_NEAREST_EN`: `result_type`=3.
3. Equal distances. Samples: (10,1), (10,2), (10,3), (10,0), (10,0).
   - Kept in order: types 1, 2, 3 (stability check).
   - Required: `result_type`=1 in both builds.
4. All-ones distance. Samples: (32'hFFFFFFFF,2), then four samples (32'hFFFFFFFF,1).
   - Kept types: 2, 1, 1.
   - Required: `result_type`=1, `nearest_dist`=32'hFFFFFFFF.
5. Reset mid-query. Pulse `rst` after the 3rd `done`.
   - Required: all outputs return to reset values next cycle, and no `result_valid`.
   - A following `start` with scenario 1's data gives `result_type`=2.
6. Ignored inputs.
   - A spurious `done` in REQ or VOTE changes no slot.
   - `start` while `busy` is ignored.
   - Back-to-back queries: `start` in the `result_valid` cycle begins a new query, with `data_request` in the next cycle.
